wb_rr_arbiter: RTL and testbench



---
 rtl/ecap5_dproc_pkg.sv | 24 ++
 rtl/wb_rr_arbiter_picker.sv | 27 ++
 rtl/wb_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types and helpers for the data-processor bus fabric.
// Holds the arbiter state encoding and a one-hot to index converter.
package ecap5_dproc_pkg;

    localparam int ARB_MAX_PORTS = 8;
    localparam int ARB_IDX_W     = $clog2(ARB_MAX_PORTS);

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_PORTS-1:0] onehot);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_PORTS; i++) begin
            if (onehot[i]) begin
                idx = ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_picker.sv
// Combinational round-robin priority encoder: the first requester after
// `last` (wrapping) wins; valid is low when nobody requests.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // k is the distance from last; the nearest requesting port wins
        for (int k = 1; k <= N; k++) begin
            for (int p = 0; p < N; p++) begin
                if (!valid && req[p] && (p == (int'(last) + k) % N)) begin
                    grant[p] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin pipelined Wishbone arbiter: one owner holds the master port for
// its whole CYC, with issue throttled by an outstanding-request counter.
module wb_rr_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int NUM_PORTS       = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [32*NUM_PORTS-1:0] s_wb_adr_i,
    input  logic [32*NUM_PORTS-1:0] s_wb_dat_i,
    input  logic [NUM_PORTS-1:0]    s_wb_we_i,
    input  logic [4*NUM_PORTS-1:0]  s_wb_sel_i,
    input  logic [NUM_PORTS-1:0]    s_wb_stb_i,
    input  logic [NUM_PORTS-1:0]    s_wb_cyc_i,
    output logic [32*NUM_PORTS-1:0] s_wb_dat_o,
    output logic [NUM_PORTS-1:0]    s_wb_ack_o,
    output logic [NUM_PORTS-1:0]    s_wb_stall_o,
    output logic [31:0]             m_wb_adr_o,
    output logic [31:0]             m_wb_dat_o,
    output logic                    m_wb_we_o,
    output logic [3:0]              m_wb_sel_o,
    output logic                    m_wb_stb_o,
    output logic                    m_wb_cyc_o,
    input  logic [31:0]             m_wb_dat_i,
    input  logic                    m_wb_ack_i,
    input  logic                    m_wb_stall_i,
    output logic [NUM_PORTS-1:0]    grant_o
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    arb_state_t           state_reg, state_next;
    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic [IW-1:0]        last_reg, last_next;
    logic [CW-1:0]        cnt_reg, cnt_next;

    logic [31:0]          adr_arr [NUM_PORTS];
    logic [31:0]          dat_arr [NUM_PORTS];
    logic [3:0]           sel_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] pick_grant;
    logic                 pick_valid;
    logic                 owned;
    logic                 full;
    logic                 accept;

    assign owned = (state_reg == ARB_OWNED);
    assign full  = (cnt_reg == CNT_MAX);
    assign req   = s_wb_cyc_i & s_wb_stb_i;

    // last_reg doubles as the owner index while OWNED
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic is_owner;
            assign is_owner     = owned && (last_reg == IW'(gi));
            assign adr_arr[gi]  = s_wb_adr_i[32*gi +: 32];
            assign dat_arr[gi]  = s_wb_dat_i[32*gi +: 32];
            assign sel_arr[gi]  = s_wb_sel_i[4*gi +: 4];
            assign s_wb_dat_o[32*gi +: 32] = is_owner ? m_wb_dat_i : 32'h0;
            assign s_wb_ack_o[gi]   = is_owner && m_wb_ack_i;
            assign s_wb_stall_o[gi] = !is_owner || m_wb_stall_i || full;
        end
    endgenerate

    rr_picker #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .last  (last_reg),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        m_wb_adr_o = '0;
        m_wb_dat_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_sel_o = '0;
        m_wb_stb_o = 1'b0;
        m_wb_cyc_o = 1'b0;
        if (owned) begin
            m_wb_adr_o = adr_arr[last_reg];
            m_wb_dat_o = dat_arr[last_reg];
            m_wb_we_o  = s_wb_we_i[last_reg];
            m_wb_sel_o = sel_arr[last_reg];
            m_wb_stb_o = s_wb_stb_i[last_reg] && !full;
            m_wb_cyc_o = s_wb_cyc_i[last_reg];
        end
    end

    assign accept  = m_wb_stb_o && !m_wb_stall_i;
    assign grant_o = grant_reg;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = ARB_OWNED;
                    grant_next = pick_grant;
                    last_next  = IW'(onehot_to_idx(ARB_MAX_PORTS'(pick_grant)));
                    cnt_next   = '0;
                end
            end
            ARB_OWNED: begin
                // dropping CYC aborts whatever is still outstanding
                if (!s_wb_cyc_i[last_reg]) begin
                    state_next = ARB_IDLE;
                    grant_next = '0;
                    cnt_next   = '0;
                end else if (accept && !m_wb_ack_i) begin
                    cnt_next = cnt_reg + CW'(1);
                end else if (!accept && m_wb_ack_i && (cnt_reg != '0)) begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ARB_IDLE;
            grant_reg <= '0;
            last_reg  <= IW'(NUM_PORTS - 1);
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a per-cycle reference model checks every
// output at each falling edge; literal checks pin key moments of the scenario.
module tb_wb_rr_arbiter;

    localparam int NP   = 3;
    localparam int MAXO = 4;

    logic               clk_i  = 1'b0;
    logic               rst_ni = 1'b0;
    logic [32*NP-1:0]   s_wb_adr_i, s_wb_dat_i, s_wb_dat_o;
    logic [NP-1:0]      s_wb_we_i, s_wb_stb_i, s_wb_cyc_i;
    logic [NP-1:0]      s_wb_ack_o, s_wb_stall_o, grant_o;
    logic [4*NP-1:0]    s_wb_sel_i;
    logic [31:0]        m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
    logic [3:0]         m_wb_sel_o;
    logic               m_wb_we_o, m_wb_stb_o, m_wb_cyc_o;
    logic               m_wb_ack_i, m_wb_stall_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    always #5 clk_i = ~clk_i;

    wb_rr_arbiter #(
        .NUM_PORTS       (NP),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .s_wb_adr_i   (s_wb_adr_i),
        .s_wb_dat_i   (s_wb_dat_i),
        .s_wb_we_i    (s_wb_we_i),
        .s_wb_sel_i   (s_wb_sel_i),
        .s_wb_stb_i   (s_wb_stb_i),
        .s_wb_cyc_i   (s_wb_cyc_i),
        .s_wb_dat_o   (s_wb_dat_o),
        .s_wb_ack_o   (s_wb_ack_o),
        .s_wb_stall_o (s_wb_stall_o),
        .m_wb_adr_o   (m_wb_adr_o),
        .m_wb_dat_o   (m_wb_dat_o),
        .m_wb_we_o    (m_wb_we_o),
        .m_wb_sel_o   (m_wb_sel_o),
        .m_wb_stb_o   (m_wb_stb_o),
        .m_wb_cyc_o   (m_wb_cyc_o),
        .m_wb_dat_i   (m_wb_dat_i),
        .m_wb_ack_i   (m_wb_ack_i),
        .m_wb_stall_i (m_wb_stall_i),
        .grant_o      (grant_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = nobody), last winner, outstanding count
    int mo = -1;
    int ml = NP - 1;
    int mc = 0;
    int nmo, nml, nmc;
    logic [NP-1:0]    e_grant, e_stall, e_ack;
    logic [32*NP-1:0] e_sdat;
    logic [31:0]      e_adr, e_dat;
    logic [3:0]       e_sel;
    logic             e_we, e_stb, e_cyc, e_acc;

    always @(negedge clk_i) begin
        e_grant = '0; e_stall = '1; e_ack = '0; e_sdat = '0;
        e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0;
        if (mo >= 0) begin
            e_grant[mo] = 1'b1;
            e_adr = s_wb_adr_i[32*mo +: 32];
            e_dat = s_wb_dat_i[32*mo +: 32];
            e_sel = s_wb_sel_i[4*mo +: 4];
            e_we  = s_wb_we_i[mo];
            e_cyc = s_wb_cyc_i[mo];
            e_stb = s_wb_stb_i[mo] && (mc < MAXO);
            e_stall[mo] = m_wb_stall_i || (mc == MAXO);
            e_ack[mo] = m_wb_ack_i;
            e_sdat[32*mo +: 32] = m_wb_dat_i;
        end
        chk("grant", 128'(grant_o), 128'(e_grant));
        chk("m_adr", 128'(m_wb_adr_o), 128'(e_adr));
        chk("m_dat", 128'(m_wb_dat_o), 128'(e_dat));
        chk("m_sel", 128'(m_wb_sel_o), 128'(e_sel));
        chk("m_we", 128'(m_wb_we_o), 128'(e_we));
        chk("m_stb", 128'(m_wb_stb_o), 128'(e_stb));
        chk("m_cyc", 128'(m_wb_cyc_o), 128'(e_cyc));
        chk("s_stall", 128'(s_wb_stall_o), 128'(e_stall));
        chk("s_ack", 128'(s_wb_ack_o), 128'(e_ack));
        chk("s_dat", 128'(s_wb_dat_o), 128'(e_sdat));

        nmo = mo; nml = ml; nmc = mc;
        if (mo < 0) begin
            for (int k = 1; k <= NP; k++) begin
                if (nmo < 0 && s_wb_cyc_i[(ml + k) % NP] && s_wb_stb_i[(ml + k) % NP]) begin
                    nmo = (ml + k) % NP;
                    nml = nmo;
                    nmc = 0;
                end
            end
        end else if (!s_wb_cyc_i[mo]) begin
            nmo = -1;
            nmc = 0;
        end else begin
            e_acc = e_stb && !m_wb_stall_i;
            if (e_acc && !m_wb_ack_i) nmc = mc + 1;
            else if (!e_acc && m_wb_ack_i && mc > 0) nmc = mc - 1;
        end
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mo <= -1;
            ml <= NP - 1;
            mc <= 0;
        end else begin
            mo <= nmo;
            ml <= nml;
            mc <= nmc;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
        cyc_n++;
        m_wb_dat_i = 32'hCAFE_0000 + 32'(cyc_n);
    endtask

    task automatic req(input int p, input logic v);
        s_wb_cyc_i[p] = v;
        s_wb_stb_i[p] = v;
    endtask

    task automatic do_reset();
        s_wb_cyc_i = '0; s_wb_stb_i = '0; m_wb_ack_i = 1'b0; m_wb_stall_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    logic [NP-1:0] rr_exp [4];
    int            rr_idx [4];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_idx = '{0, 1, 2, 0};
        for (int p = 0; p < NP; p++) begin
            s_wb_adr_i[32*p +: 32] = 32'h1000_0040 + 32'h1000_0000 * 32'(p);
            s_wb_dat_i[32*p +: 32] = 32'hD000_0000 + 32'(p);
            s_wb_sel_i[4*p +: 4]   = 4'(1 << p);
            s_wb_we_i[p]           = (p % 2) == 1;
        end
        s_wb_cyc_i = '0; s_wb_stb_i = '0;
        m_wb_ack_i = 1'b0; m_wb_stall_i = 1'b0; m_wb_dat_i = 32'hCAFE_0000;

        // reset state, then single requester on port 0
        tick(); tick();
        #1;
        chk("rst_grant", 128'(grant_o), 128'(3'b000));
        chk("rst_stall", 128'(s_wb_stall_o), 128'(3'b111));
        chk("rst_mcyc", 128'(m_wb_cyc_o), 128'(1'b0));
        rst_ni = 1'b1;
        req(0, 1'b1);
        #1 chk("t1_grant_n", 128'(grant_o), 128'(3'b000));
        tick();
        #1;
        chk("t1_grant", 128'(grant_o), 128'(3'b001));
        chk("t1_adr", 128'(m_wb_adr_o), 128'(32'h1000_0040));
        chk("t1_stall", 128'(s_wb_stall_o), 128'(3'b110));
        chk("t1_mcyc", 128'(m_wb_cyc_o), 128'(1'b1));
        tick();
        s_wb_stb_i[0] = 1'b0;
        m_wb_ack_i = 1'b1;
        #1 chk("t1_ack", 128'(s_wb_ack_o), 128'(3'b001));
        tick();
        m_wb_ack_i = 1'b0;
        req(0, 1'b0);
        tick();
        #1 chk("t1_idle", 128'(grant_o), 128'(3'b000));

        // round robin with all three requesting
        do_reset();
        req(0, 1'b1); req(1, 1'b1); req(2, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr_grant", 128'(grant_o), 128'(rr_exp[i]));
            tick();
            req(rr_idx[i], 1'b0);
            #1 chk("rr_hold", 128'(grant_o), 128'(rr_exp[i]));
            tick();
            #1 chk("rr_dead", 128'(grant_o), 128'(3'b000));
            req(rr_idx[i], 1'b1);
            tick();
        end
        s_wb_cyc_i = '0; s_wb_stb_i = '0;
        tick();

        // outstanding limit on port 0
        do_reset();
        m_wb_stall_i = 1'b1;
        req(0, 1'b1);
        tick();
        #1;
        chk("st_mstall", 128'(s_wb_stall_o), 128'(3'b111));
        chk("st_mstb", 128'(m_wb_stb_o), 128'(1'b1));
        m_wb_stall_i = 1'b0;
        tick(); tick(); tick(); tick();
        #1;
        chk("full_stall", 128'(s_wb_stall_o), 128'(3'b111));
        chk("full_stb", 128'(m_wb_stb_o), 128'(1'b0));
        chk("full_mcnt", 128'(mc), 128'(4));
        m_wb_ack_i = 1'b1;
        #1;
        chk("full_ack_stall", 128'(s_wb_stall_o[0]), 128'(1'b1));
        chk("full_ack", 128'(s_wb_ack_o), 128'(3'b001));
        tick();
        m_wb_ack_i = 1'b0;
        #1;
        chk("fifth_stall", 128'(s_wb_stall_o), 128'(3'b110));
        chk("fifth_stb", 128'(m_wb_stb_o), 128'(1'b1));
        tick();
        #1 chk("refull_mcnt", 128'(mc), 128'(4));

        // accept + ack together, then spurious ack at zero
        s_wb_stb_i[0] = 1'b0;
        m_wb_ack_i = 1'b1;
        tick(); tick();
        s_wb_stb_i[0] = 1'b1;
        #1 chk("aa_mcnt_pre", 128'(mc), 128'(2));
        tick();
        #1 chk("aa_mcnt", 128'(mc), 128'(2));
        s_wb_stb_i[0] = 1'b0;
        tick(); tick();
        #1 chk("sp_ack", 128'(s_wb_ack_o), 128'(3'b001));
        tick();
        #1 chk("sp_mcnt", 128'(mc), 128'(0));
        m_wb_ack_i = 1'b0;
        s_wb_stb_i[0] = 1'b1;
        tick(); tick(); tick(); tick();
        #1 chk("sp_full", 128'(s_wb_stall_o), 128'(3'b111));

        // owner drops cyc with three outstanding
        s_wb_stb_i[0] = 1'b0;
        m_wb_ack_i = 1'b1;
        tick();
        m_wb_ack_i = 1'b0;
        #1 chk("drop_mcnt", 128'(mc), 128'(3));
        req(1, 1'b1);
        req(0, 1'b0);
        #1 chk("drop_mcyc", 128'(m_wb_cyc_o), 128'(1'b0));
        tick();
        m_wb_ack_i = 1'b1;
        #1;
        chk("drop_idle", 128'(grant_o), 128'(3'b000));
        chk("drop_noack", 128'(s_wb_ack_o), 128'(3'b000));
        tick();
        #1;
        chk("new_grant", 128'(grant_o), 128'(3'b010));
        chk("new_ack", 128'(s_wb_ack_o), 128'(3'b010));
        chk("new_stall", 128'(s_wb_stall_o), 128'(3'b101));
        m_wb_ack_i = 1'b0;
        tick(); tick();

        // asynchronous reset mid-burst
        rst_ni = 1'b0;
        m_wb_ack_i = 1'b1;
        #1;
        chk("ar_mcyc", 128'(m_wb_cyc_o), 128'(1'b0));
        chk("ar_grant", 128'(grant_o), 128'(3'b000));
        chk("ar_stall", 128'(s_wb_stall_o), 128'(3'b111));
        chk("ar_ack", 128'(s_wb_ack_o), 128'(3'b000));
        tick();
        rst_ni = 1'b1;
        m_wb_ack_i = 1'b0;
        req(0, 1'b1); req(2, 1'b1);
        tick();
        #1 chk("ar_prio", 128'(grant_o), 128'(3'b001));
        s_wb_cyc_i = '0; s_wb_stb_i = '0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
